fetch_controller: RTL and testbench

Sequencer for the instruction-fetch stage: it decides every cycle whether the program counter register advances, holds or is redirected, and it runs the instruction-memory request/ready handshake. It sits between the hazard unit, the branch/jump/exception resolution logic and the PC register. It drives the PC register's next-value and hold inputs and marks which fetched words are valid for IF/ID.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/redirect_arbiter.sv | 33 +++
 rtl/fetch_controller.sv | 122 ++++++++++++
 tb/tb_fetch_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Numeric order doubles as redirect priority.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    EXC    = 2'd3
  } redirect_kind_e;

  typedef struct packed {
    redirect_kind_e  kind;
    logic [XLEN-1:0] target;
  } redirect_t;

endpackage

// File: rtl/redirect_arbiter.sv
// Picks the single highest-priority redirect request and word-aligns its target.
module redirect_arbiter
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            exception,
  output redirect_t       redirect_c
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    redirect_c.kind = NONE;
    raw_target      = '0;
    if (exception) begin
      redirect_c.kind = EXC;
      raw_target      = EXC_VECTOR;
    end else if (jump) begin
      redirect_c.kind = JUMP;
      raw_target      = jump_target;
    end else if (branch_taken) begin
      redirect_c.kind = BRANCH;
      raw_target      = branch_target;
    end
    redirect_c.target = {raw_target[XLEN-1:2], 2'b00};
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: PC advance/hold/redirect decisions and imem handshake.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pcCurrent,
  input  logic            stall,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            jump,
  input  logic [XLEN-1:0] jumpTarget,
  input  logic            exception,
  input  logic            imemReady,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  output logic [XLEN-1:0] pcNext,
  output logic            pcHold,
  output logic            fetchValid,
  output logic            flush
);

  fetch_state_e state_q, state_d;
  redirect_t    pend_q, pend_d;
  redirect_t    redir;
  redirect_t    drain_sel;

  redirect_arbiter #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_arb (
    .branch_taken (branchTaken),
    .branch_target(branchTarget),
    .jump         (jump),
    .jump_target  (jumpTarget),
    .exception    (exception),
    .redirect_c   (redir)
  );

  assign imemAddr = pcCurrent;

  // A fresh redirect overrides the pending one only at equal or higher priority.
  always_comb begin
    drain_sel = pend_q;
    if (redir.kind >= pend_q.kind) drain_sel = redir;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (redir.kind != NONE && !imemReady) begin
          pend_d  = redir;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imemReady) begin
          pend_d  = '0;
          state_d = FETCH;
        end else begin
          pend_d = drain_sel;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imemReq    = 1'b0;
    pcNext     = RESET_VECTOR;
    pcHold     = 1'b0;
    fetchValid = 1'b0;
    flush      = 1'b0;
    case (state_q)
      BOOT: ;
      FETCH: begin
        imemReq = 1'b1;
        pcNext  = pcCurrent;
        if (redir.kind != NONE) begin
          if (imemReady) begin
            pcNext = redir.target;
            flush  = 1'b1;
          end else begin
            pcHold = 1'b1;
          end
        end else if (stall || !imemReady) begin
          pcHold = 1'b1;
        end else begin
          pcNext     = pcCurrent + PC_STEP;
          fetchValid = 1'b1;
        end
      end
      DRAIN: begin
        imemReq = 1'b1;
        pcNext  = pcCurrent;
        pcHold  = 1'b1;
        if (imemReady) begin
          pcNext = drain_sel.target;
          pcHold = 1'b0;
          flush  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed scenarios plus randomized traffic.
module tb_fetch_controller;

  localparam logic [31:0] EXC_V = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pcCurrent = '0;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        jump = 1'b0;
  logic [31:0] jumpTarget = '0;
  logic        exception = 1'b0;
  logic        imemReady = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] pcNext;
  logic        pcHold;
  logic        fetchValid;
  logic        flush;

  fetch_controller dut (
    .clk         (clk),
    .reset       (reset),
    .pcCurrent   (pcCurrent),
    .stall       (stall),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jump        (jump),
    .jumpTarget  (jumpTarget),
    .exception   (exception),
    .imemReady   (imemReady),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .pcNext      (pcNext),
    .pcHold      (pcHold),
    .fetchValid  (fetchValid),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] nxt;
    logic        chk_nxt;
    logic        hold;
    logic        fv;
    logic        fl;
    int          cyc;
  } exp_t;

  typedef struct {
    int          prio;
    logic [31:0] tgt;
  } rd_t;

  exp_t exp_q[$];
  rd_t  m_pend[$];
  int   m_mode = 0;  // 0: just out of reset, 1: fetching, 2: waiting for memory before redirect
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, c, act, expv);
    end
  endtask

  // Drive one cycle of inputs and push what the reference model says the outputs must be.
  task automatic step(input logic rst_i, input logic stall_i, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic ex, input logic rdy,
                      input logic [31:0] pc);
    rd_t  r;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_i; stall = stall_i; branchTaken = br; branchTarget = bt;
    jump = jp; jumpTarget = jt; exception = ex; imemReady = rdy; pcCurrent = pc;
    cyc++;
    r.prio = 0; r.tgt = '0;
    if (ex)      begin r.prio = 3; r.tgt = EXC_V; end
    else if (jp) begin r.prio = 2; r.tgt = jt & 32'hFFFF_FFFC; end
    else if (br) begin r.prio = 1; r.tgt = bt & 32'hFFFF_FFFC; end
    e.req = 1'b0; e.addr = pc; e.nxt = 32'h0; e.chk_nxt = 1'b1;
    e.hold = 1'b0; e.fv = 1'b0; e.fl = 1'b0; e.cyc = cyc;
    if (!rst_i) begin
      m_mode = 0;
      m_pend.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      e.req = 1'b1;
      if (r.prio > 0) begin
        if (rdy) begin
          e.nxt = r.tgt; e.fl = 1'b1;
        end else begin
          e.hold = 1'b1; e.chk_nxt = 1'b0;
          m_pend.push_back(r);
          m_mode = 2;
        end
      end else if (!stall_i && rdy) begin
        e.nxt = pc + 32'd4; e.fv = 1'b1;
      end else begin
        e.hold = 1'b1; e.chk_nxt = 1'b0;
      end
    end else begin
      e.req = 1'b1;
      if (r.prio > 0 && r.prio >= m_pend[0].prio) begin
        m_pend.delete();
        m_pend.push_back(r);
      end
      if (rdy) begin
        e.nxt = m_pend[0].tgt; e.fl = 1'b1;
        m_pend.delete();
        m_mode = 1;
      end else begin
        e.hold = 1'b1; e.chk_nxt = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare outputs mid-cycle against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imemReq",    e.cyc, 32'(imemReq),    32'(e.req));
        check("imemAddr",   e.cyc, imemAddr,        e.addr);
        check("pcHold",     e.cyc, 32'(pcHold),     32'(e.hold));
        check("fetchValid", e.cyc, 32'(fetchValid), 32'(e.fv));
        check("flush",      e.cyc, 32'(flush),      32'(e.fl));
        if (e.chk_nxt) check("pcNext", e.cyc, pcNext, e.nxt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    // Reset, boot and sequential fetch
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h4);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h8);
    // Stall holds the PC
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 1, 32'h20);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h20);
    // Branch with memory ready, misaligned target
    step(1, 0, 1, 32'h103, 0, 0, 0, 1, 32'h24);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    // Pending jump survives a lower-priority branch
    step(1, 0, 0, 0, 1, 32'h200, 0, 0, 32'h104);
    step(1, 0, 1, 32'h300, 0, 0, 0, 0, 32'h104);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h104);
    // Exception on the ready cycle beats the pending jump
    step(1, 0, 0, 0, 1, 32'h200, 0, 0, 32'h200);
    step(1, 1, 1, 32'h300, 0, 0, 0, 0, 32'h200);
    step(1, 0, 0, 0, 0, 0, 1, 1, 32'h200);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h80);
    // Wrap of pc+4
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    // Reset while draining: outputs drop immediately, pending discarded
    step(1, 0, 0, 0, 1, 32'h400, 0, 0, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    m_mode = 0;
    m_pend.delete();
    check("async_rst_imemReq",    cyc, 32'(imemReq),    32'h0);
    check("async_rst_pcNext",     cyc, pcNext,          32'h0);
    check("async_rst_pcHold",     cyc, 32'(pcHold),     32'h0);
    check("async_rst_fetchValid", cyc, 32'(fetchValid), 32'h0);
    check("async_rst_flush",      cyc, 32'(flush),      32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, $urandom(),
           $urandom_range(0, 11) == 0, $urandom(),
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, pc);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drain", cyc, 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
